// File: rtl/mini_mips_pkg.sv
// mini_mips_pkg: shared encodings for the miniMIPS multi-cycle control unit.
// Opcodes, funct/alu_op codes, ALU B / PC source selects and FSM state codes.
package mini_mips_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_ORI   = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_BNE   = 4'h7;
  localparam logic [3:0] OP_J     = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hf;

  localparam logic [2:0] FN_ILLEGAL = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_EXEC_R   = 4'd3;
  localparam state_t S_WB_R     = 4'd4;
  localparam state_t S_EXEC_I   = 4'd5;
  localparam state_t S_WB_I     = 4'd6;
  localparam state_t S_MEM_ADDR = 4'd7;
  localparam state_t S_MEM_RD   = 4'd8;
  localparam state_t S_WB_MEM   = 4'd9;
  localparam state_t S_MEM_WR   = 4'd10;
  localparam state_t S_BRANCH   = 4'd11;
  localparam state_t S_JUMP     = 4'd12;
  localparam state_t S_TRAP     = 4'd13;

endpackage

// File: rtl/mini_mips_alu_dec.sv
// mini_mips_alu_dec: ALU operation select from {state, opcode, funct}.
// Ports: state/opcode/funct in; alu_op out, illegal_funct (R-type funct 111).
module mini_mips_alu_dec
  import mini_mips_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal_funct
);

  assign illegal_funct = (opcode == OP_RTYPE) &&
                         (funct == FN_ILLEGAL);

  always_comb begin
    alu_op = ALU_ADD;
    unique case (1'b1)
      (state == S_EXEC_R): alu_op = funct;
      (state == S_EXEC_I): begin
        if (opcode == OP_ANDI)
          alu_op = ALU_AND;
        else if (opcode == OP_ORI)
          alu_op = ALU_OR;
        else
          alu_op = ALU_ADD;
      end
      (state == S_BRANCH): alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mini_mips_mc_ctrl.sv
// mini_mips_mc_ctrl: multi-cycle FSM sequencing the miniMIPS datapath.
// In: run/opcode/funct/zero/mem_ready; out: datapath controls, busy,
// sticky illegal, retired count when MINIMIPS_RETIRE_CNT_EN is defined.
module mini_mips_mc_ctrl
  import mini_mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       illegal
`ifdef MINIMIPS_RETIRE_CNT_EN
  ,
  output logic [15:0] retired
`endif
);

  state_t state;
  state_t state_nx;
  logic   fin;
  logic   illegal_funct;

  mini_mips_alu_dec u_alu_dec (
    .state         (state),
    .opcode        (opcode),
    .funct         (funct),
    .alu_op        (alu_op),
    .illegal_funct (illegal_funct)
  );

  // fin marks the last cycle of an instruction; run picks what follows.
  always_comb begin
    state_nx = state;
    fin      = 1'b0;
    unique case (state)
      S_IDLE:  if (run) state_nx = S_FETCH;
      S_FETCH: if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:
            state_nx = illegal_funct ? S_TRAP : S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI:
            state_nx = S_EXEC_I;
          OP_LW, OP_SW:
            state_nx = S_MEM_ADDR;
          OP_BEQ, OP_BNE:
            state_nx = S_BRANCH;
          OP_J:    state_nx = S_JUMP;
          OP_HALT: state_nx = S_IDLE;
          default: state_nx = S_TRAP;
        endcase
      end
      S_EXEC_R: state_nx = S_WB_R;
      S_EXEC_I: state_nx = S_WB_I;
      S_MEM_ADDR:
        state_nx = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_nx = S_WB_MEM;
      S_MEM_WR: fin = mem_ready;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP:
        fin = 1'b1;
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_IDLE;
    endcase
    if (fin)
      state_nx = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal <= 1'b0;
    else if (state_nx == S_TRAP)
      illegal <= 1'b1;
  end

`ifdef MINIMIPS_RETIRE_CNT_EN
  // halt retires in DECODE, every other instruction on its fin cycle.
  logic retire;
  assign retire = fin ||
                  ((state == S_DECODE) && (opcode == OP_HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired <= '0;
    else if (retire)
      retired <= retired + 16'd1;
  end
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCS_ALU;
    unique case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        alu_src_b = SRCB_ONE;
      end
      S_DECODE: alu_src_b = SRCB_SEXT;
      S_EXEC_R: alu_src_a = 1'b1;
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = (opcode == OP_ADDI) ? SRCB_SEXT
                                        : SRCB_ZEXT;
      end
      S_WB_I: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PCS_ALUOUT;
        pc_en     = (opcode == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pc_en  = 1'b1;
        pc_src = PCS_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mini_mips_mc_ctrl.sv
// tb_mini_mips_mc_ctrl: directed bench for the miniMIPS multi-cycle control.
// Compares the packed control word per cycle against hand-built vectors.
module tb_mini_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [2:0] funct = 3'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic       busy, illegal;
`ifdef MINIMIPS_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mini_mips_mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .busy       (busy),
    .illegal    (illegal)
`ifdef MINIMIPS_RETIRE_CNT_EN
    ,
    .retired    (retired)
`endif
  );

  // {pc_en,ir_write,mem_read,mem_write,iord,reg_write,reg_dst,
  //  mem_to_reg,alu_src_a,alu_src_b,pc_src,alu_op,busy}
  logic [16:0] ctl;
  assign ctl = {pc_en, ir_write, mem_read, mem_write, iord,
                reg_write, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, pc_src, alu_op, busy};

  function automatic logic [16:0] mk(
    input logic pe, input logic iw, input logic mr,
    input logic mw, input logic io, input logic rw,
    input logic rd, input logic mtr, input logic asa,
    input logic [1:0] asb, input logic [1:0] ps,
    input logic [2:0] op, input logic b);
    return {pe, iw, mr, mw, io, rw, rd, mtr, asa,
            asb, ps, op, b};
  endfunction

  localparam logic [16:0] E_IDLE  = 17'h0;
  localparam logic [16:0] E_FETCH =
    mk(1,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b000,1);
  localparam logic [16:0] E_FETCHW =
    mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b000,1);
  localparam logic [16:0] E_DEC =
    mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,3'b000,1);
  localparam logic [16:0] E_EXR_ADD =
    mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,1);
  localparam logic [16:0] E_WBR =
    mk(0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,1);
  localparam logic [16:0] E_EXI_ORI =
    mk(0,0,0,0,0,0,0,0,1,2'b11,2'b00,3'b011,1);
  localparam logic [16:0] E_WBI =
    mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,1);
  localparam logic [16:0] E_MADDR =
    mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,1);
  localparam logic [16:0] E_MRD =
    mk(0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b000,1);
  localparam logic [16:0] E_WBM =
    mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,1);
  localparam logic [16:0] E_MWR =
    mk(0,0,0,1,1,0,0,0,0,2'b00,2'b00,3'b000,1);
  localparam logic [16:0] E_BR_TAKEN =
    mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,1);
  localparam logic [16:0] E_BR_NOT =
    mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,1);
  localparam logic [16:0] E_JMP =
    mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,1);
  localparam logic [16:0] E_TRAP =
    mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1);

  task automatic do_reset();
    run = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    opcode = 4'h0; funct = 3'h0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    run = 1'b1;
    #1;
    checks++;
    if (ctl !== E_IDLE || illegal !== 1'b0) begin
      $display("FAIL reset_async ctl=%h ill=%b want %h 0",
               ctl, illegal, E_IDLE);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (ctl !== E_IDLE) begin
      $display("FAIL reset_hold ctl=%h want %h", ctl, E_IDLE);
      errors++;
    end
`ifdef MINIMIPS_RETIRE_CNT_EN
    checks++;
    if (retired !== 16'h0) begin
      $display("FAIL reset_retired got %h want 0", retired);
      errors++;
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_r_add();
    logic [16:0] exp [5];
    exp = '{E_FETCH, E_DEC, E_EXR_ADD, E_WBR, E_IDLE};
    do_reset();
    opcode = 4'h0; funct = 3'b000; run = 1'b1;
    #1;
    checks++;
    if (ctl !== E_IDLE) begin
      $display("FAIL radd_idle ctl=%h want %h", ctl, E_IDLE);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 3) run = 1'b0;
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        $display("FAIL radd[%0d] ctl=%h want %h", i, ctl, exp[i]);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e;
    do_reset();
    opcode = 4'h0; run = 1'b1;
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (c == 0) funct = 3'(k);
        if (k == 6 && c == 3) run = 1'b0;
        #1;
        case (c)
          0: e = E_FETCH;
          1: e = E_DEC;
          2: e = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'(k),1);
          default: e = E_WBR;
        endcase
        checks++;
        if (ctl !== e) begin
          $display("FAIL b2b[f%0d c%0d] ctl=%h want %h",
                   k, c, ctl, e);
          errors++;
        end
      end
    end
    @(posedge clk); #2;
    checks++;
    if (ctl !== E_IDLE) begin
      $display("FAIL b2b_end ctl=%h want %h", ctl, E_IDLE);
      errors++;
    end
  endtask

  task automatic test_lw_wait();
    logic [16:0] exp [8];
    logic        mrv [8];
    exp = '{E_FETCH, E_DEC, E_MADDR, E_MRD, E_MRD, E_MRD,
            E_WBM, E_IDLE};
    mrv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    opcode = 4'h4; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      mem_ready = mrv[i];
      if (i == 6) run = 1'b0;
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        $display("FAIL lw[%0d] ctl=%h want %h", i, ctl, exp[i]);
        errors++;
      end
    end
  endtask

  task automatic test_branch();
    logic [16:0] exp [7];
    exp = '{E_FETCH, E_DEC, E_BR_TAKEN, E_FETCH, E_DEC,
            E_BR_NOT, E_IDLE};
    do_reset();
    opcode = 4'h6; zero = 1'b1; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 3) opcode = 4'h7;
      if (i == 5) run = 1'b0;
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        $display("FAIL branch[%0d] ctl=%h want %h",
                 i, ctl, exp[i]);
        errors++;
      end
    end
  endtask

  task automatic test_jump_halt();
    logic [16:0] exp [8];
    logic        mrv [8];
    exp = '{E_FETCHW, E_FETCH, E_DEC, E_JMP, E_FETCH, E_DEC,
            E_IDLE, E_IDLE};
    mrv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    opcode = 4'h8; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      mem_ready = mrv[i];
      if (i == 4) opcode = 4'hf;
      if (i == 6) run = 1'b0;
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        $display("FAIL jhalt[%0d] ctl=%h want %h",
                 i, ctl, exp[i]);
        errors++;
      end
    end
`ifdef MINIMIPS_RETIRE_CNT_EN
    checks++;
    if (retired !== 16'd2) begin
      $display("FAIL jhalt_retired got %0d want 2", retired);
      errors++;
    end
`endif
  endtask

  task automatic test_trap();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      checks++;
      if (illegal !== 1'b0) begin
        $display("FAIL trap_clr[%0d] ill=%b want 0", t, illegal);
        errors++;
      end
      opcode = (t == 0) ? 4'ha : 4'h0;
      funct  = (t == 0) ? 3'b000 : 3'b111;
      run = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #1;
      run = 1'b0;
      #1;
      checks++;
      if (ctl !== E_DEC) begin
        $display("FAIL trap_dec[%0d] ctl=%h want %h",
                 t, ctl, E_DEC);
        errors++;
      end
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #2;
        checks++;
        if (ctl !== E_TRAP || illegal !== 1'b1) begin
          $display("FAIL trap[%0d.%0d] ctl=%h ill=%b want %h 1",
                   t, i, ctl, illegal, E_TRAP);
          errors++;
        end
      end
`ifdef MINIMIPS_RETIRE_CNT_EN
      checks++;
      if (retired !== 16'd0) begin
        $display("FAIL trap_retired got %0d want 0", retired);
        errors++;
      end
`endif
    end
  endtask

  task automatic test_run_drop();
    logic [16:0] exp [5];
    exp = '{E_FETCH, E_DEC, E_EXI_ORI, E_WBI, E_IDLE};
    do_reset();
    opcode = 4'h3; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 2) run = 1'b0;
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        $display("FAIL ori[%0d] ctl=%h want %h", i, ctl, exp[i]);
        errors++;
      end
    end
`ifdef MINIMIPS_RETIRE_CNT_EN
    checks++;
    if (retired !== 16'd1) begin
      $display("FAIL ori_retired got %0d want 1", retired);
      errors++;
    end
`endif
  endtask

  task automatic test_reset_mid_mem();
    logic [16:0] exp [9];
    exp = '{E_FETCH, E_DEC, E_EXR_ADD, E_WBR, E_FETCH, E_DEC,
            E_MADDR, E_MWR, E_MWR};
    do_reset();
    opcode = 4'h0; funct = 3'b000; run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 4) opcode = 4'h5;
      if (i >= 7) mem_ready = 1'b0;
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        $display("FAIL swrst[%0d] ctl=%h want %h",
                 i, ctl, exp[i]);
        errors++;
      end
    end
`ifdef MINIMIPS_RETIRE_CNT_EN
    checks++;
    if (retired !== 16'd1) begin
      $display("FAIL swrst_pre_retired got %0d want 1", retired);
      errors++;
    end
`endif
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || ctl !== E_IDLE ||
        illegal !== 1'b0) begin
      $display("FAIL swrst_async mw=%b ctl=%h ill=%b want 0 %h 0",
               mem_write, ctl, illegal, E_IDLE);
      errors++;
    end
`ifdef MINIMIPS_RETIRE_CNT_EN
    checks++;
    if (retired !== 16'd0) begin
      $display("FAIL swrst_retired got %0d want 0", retired);
      errors++;
    end
`endif
    run = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_back_to_back();
    test_lw_wait();
    test_branch();
    test_jump_halt();
    test_trap();
    test_run_drop();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
